// File: rtl/gf14_reduce_seq.sv
// Iterative GF(2^14) reduction of a 27-bit carry-less product: folds BPC high
// coefficients per cycle into the low bits, with valid/ready on both sides.
module gf14_reduce_seq #(
  // bit i = coefficient of x^i; x^14 is implicit (default x^14+x^5+x^3+x+1)
  parameter logic [13:0] POLY_TAPS = 14'b00000000101011,
  parameter int          BPC       = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:26] p,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [0:13] r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

  localparam logic [4:0] STEP = 5'(BPC);

  state_t      state;
  logic [0:26] w;
  logic [0:26] w_fold;
  logic [4:0]  deg;
  logic        last_fold;

  // Fold degrees deg down to deg-BPC+1 (never below 14), highest first so a
  // fold that sets a lower pending bit is picked up within the same cycle.
  always_comb begin
    w_fold = w;
    for (int j = 26; j >= 14; j--) begin
      if (j <= int'(deg) && j > int'(deg) - BPC && w_fold[j]) begin
        w_fold[j] = 1'b0;
        for (int i = 0; i < 14; i++) begin
          w_fold[j-14+i] = w_fold[j-14+i] ^ POLY_TAPS[i];
        end
      end
    end
  end

  assign last_fold = (int'(deg) <= 13 + BPC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      w         <= '0;
      deg       <= '0;
      r         <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            w     <= p;
            deg   <= 5'd26;
            state <= REDUCE;
          end
        end
        REDUCE: begin
          w <= w_fold;
          if (last_fold) begin
            r         <= w_fold[0:13];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            deg <= deg - STEP;
          end
        end
        DONE: begin
          // Handshake and a new accept may share a cycle: no IDLE bubble.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              w     <= p;
              deg   <= 5'd26;
              state <= REDUCE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_gf14_reduce_seq.sv
// Bench for gf14_reduce_seq: directed vectors plus a cycle-level reference
// model for BPC=1, and BPC=4/13 instances compared on random products.
module tb_gf14_reduce_seq;

  localparam logic [13:0] TAPS = 14'h002B;  // x^5+x^3+x+1

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:26] p_bus;
  logic        in_valid;
  logic        out_ready;
  logic        aux_valid;
  logic        in_ready, out_valid, busy;
  logic [0:13] r;
  logic        in_ready4, out_valid4, busy4;
  logic [0:13] r4;
  logic        in_ready13, out_valid13, busy13;
  logic [0:13] r13;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gf14_reduce_seq #(.BPC(1)) dut (
    .clk(clk), .rst_n(rst_n), .p(p_bus), .in_valid(in_valid), .in_ready(in_ready),
    .r(r), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );
  gf14_reduce_seq #(.BPC(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .p(p_bus), .in_valid(aux_valid), .in_ready(in_ready4),
    .r(r4), .out_valid(out_valid4), .out_ready(1'b1), .busy(busy4)
  );
  gf14_reduce_seq #(.BPC(13)) dut13 (
    .clk(clk), .rst_n(rst_n), .p(p_bus), .in_valid(aux_valid), .in_ready(in_ready13),
    .r(r13), .out_valid(out_valid13), .out_ready(1'b1), .busy(busy13)
  );

  function automatic logic [0:26] to_bus(input logic [26:0] v);
    logic [0:26] b;
    for (int i = 0; i < 27; i++) b[i] = v[i];
    return b;
  endfunction

  function automatic logic [26:0] from_bus(input logic [0:26] b);
    logic [26:0] v;
    for (int i = 0; i < 27; i++) v[i] = b[i];
    return v;
  endfunction

  function automatic logic [13:0] from_r(input logic [0:13] b);
    logic [13:0] v;
    for (int i = 0; i < 14; i++) v[i] = b[i];
    return v;
  endfunction

  // Schoolbook polynomial long division remainder.
  function automatic logic [13:0] gf_mod(input logic [26:0] v);
    logic [26:0] t;
    logic [26:0] m;
    t = v;
    m = {12'd0, 1'b1, TAPS};
    for (int d = 26; d >= 14; d--) begin
      if (t[d]) t = t ^ (m << (d - 14));
    end
    return t[13:0];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model for the BPC=1 instance: 13 busy cycles, then a held result.
  int          m_left;
  bit          m_done;
  logic [13:0] m_res, m_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_r    <= '0;
    end else if (m_done) begin
      if (out_ready) begin
        m_done <= 1'b0;
        if (in_valid) begin
          m_left <= 13;
          m_res  <= gf_mod(from_bus(p_bus));
        end
      end
    end else if (m_left > 0) begin
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_r    <= m_res;
      end
      m_left <= m_left - 1;
    end else if (in_valid) begin
      m_left <= 13;
      m_res  <= gf_mod(from_bus(p_bus));
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", int'(out_valid), int'(m_done));
      chk("busy", int'(busy), int'(m_done || m_left > 0));
      chk("in_ready", int'(in_ready), int'(m_left == 0 && (!m_done || out_ready)));
      if (m_done) chk("r", int'(from_r(r)), int'(m_r));
    end
  end

  // Returns one step after the accepting edge.
  task automatic send(input logic [26:0] v, input bit aux);
    bit rdy;
    bit done;
    done = 1'b0;
    p_bus     = to_bus(v);
    in_valid  = 1'b1;
    aux_valid = aux;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) done = 1'b1;
    end
    #1;
    in_valid  = 1'b0;
    aux_valid = 1'b0;
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic txn(input string name, input logic [26:0] v, input logic [13:0] exp_r);
    int lat;
    send(v, 1'b0);
    wait_out(lat);
    chk({name, "_lat"}, lat, 13);
    chk({name, "_r"}, int'(from_r(r)), int'(exp_r));
    $display("txn %s p=%07h r=%04h lat=%0d", name, v, from_r(r), lat);
  endtask

  task automatic rand_txn(input int n);
    logic [26:0] v;
    logic [13:0] e;
    int l1, l4, l13;
    v = 27'($urandom);
    e = gf_mod(v);
    l1 = 0; l4 = 0; l13 = 0;
    send(v, 1'b1);
    for (int c = 1; c <= 20 && l1 == 0; c++) begin
      @(posedge clk);
      #1;
      if (out_valid13 && l13 == 0) begin
        l13 = c;
        chk("rand_r_bpc13", int'(from_r(r13)), int'(e));
      end
      if (out_valid4 && l4 == 0) begin
        l4 = c;
        chk("rand_r_bpc4", int'(from_r(r4)), int'(e));
      end
      if (out_valid && l1 == 0) begin
        l1 = c;
        chk("rand_r_bpc1", int'(from_r(r)), int'(e));
      end
    end
    chk("rand_lat_bpc1", l1, 13);
    chk("rand_lat_bpc4", l4, 4);
    chk("rand_lat_bpc13", l13, 1);
    $display("txn rand%0d p=%07h r=%04h/%04h/%04h lat=%0d/%0d/%0d", n, v,
             from_r(r), from_r(r4), from_r(r13), l1, l4, l13);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    aux_valid = 1'b0;
    out_ready = 1'b1;
    p_bus     = '0;
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_r", int'(from_r(r)), 0);

    chk("model_x14", int'(gf_mod(27'h1 << 14)), 14'h002B);
    chk("model_x26", int'(gf_mod(27'h1 << 26)), 14'h310E);

    @(posedge clk);
    #1;
    rst_n = 1'b1;

    txn("x14", 27'h1 << 14, 14'h002B);
    txn("x26", 27'h1 << 26, 14'h310E);
    txn("zero", 27'h0, 14'h0000);
    txn("alt", 27'h0001555, 14'h1555);

    // Backpressure: let the previous result drain, then stall a result.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(27'h1 << 26, 1'b0);
    wait_out(lat);
    chk("bp_lat", lat, 13);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_r", int'(from_r(r)), 14'h310E);
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    p_bus     = to_bus(27'h1 << 14);
    in_valid  = 1'b1;
    #1;
    chk("bp_release_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_b2b_valid_low", int'(out_valid), 0);
    chk("bp_b2b_busy", int'(busy), 1);
    wait_out(lat);
    chk("bp_b2b_lat", lat, 13);
    chk("bp_b2b_r", int'(from_r(r)), 14'h002B);
    $display("txn bp_b2b p=%07h r=%04h lat=%0d", 27'h1 << 14, from_r(r), lat);

    // Reset in the sixth REDUCE cycle.
    send(27'h1 << 26, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    txn("post_rst_x26", 27'h1 << 26, 14'h310E);

    for (int n = 0; n < 1000; n++) rand_txn(n);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
